// File: rtl/adaptive_filter_pkg.sv
// ---------------------------------------------------------------------------
// adaptive_filter_pkg
//   Definitions shared by the forward adaptive filter and its inverse:
//   default sample format (Q8.6), the sample type, and the filter mode
//   encoding carried on the ctrl pin.
// ---------------------------------------------------------------------------
package adaptive_filter_pkg;

   localparam int AF_WORDLENGTH        = 14;
   localparam int AF_FRACTIONAL_LENGTH = 6;

   typedef logic signed [AF_WORDLENGTH-1:0] sample_t;

   // Mode of the forward filter: DIFF = first difference, INTEG = integrator.
   typedef enum logic {
      DIFF  = 1'b0,
      INTEG = 1'b1
   } filter_mode_t;

endpackage

// File: rtl/adaptive_filter_inverse.sv
// ---------------------------------------------------------------------------
// adaptive_filter_inverse
//   Undoes the forward adaptive filter sample-by-sample. With ctrl = DIFF the
//   forward block differentiated, so this block integrates; with ctrl = INTEG
//   it takes the first difference. Arithmetic wraps in WORDLENGTH bits so the
//   forward/inverse cascade is bit-exact.
//
// Ports
//   clk       in   clock, rising edge
//   srst      in   synchronous active-high reset
//   ctrl      in   forward-filter mode being undone (0 DIFF, 1 INTEG)
//   s_tdata   in   signed input sample
//   s_tvalid  in   input sample valid
//   s_tready  out  input accepted this cycle
//   m_tdata   out  reconstructed sample
//   m_tvalid  out  output sample valid
//   m_tready  in   downstream accepts output
// ---------------------------------------------------------------------------
module adaptive_filter_inverse
   import adaptive_filter_pkg::*;
#(
   parameter int WORDLENGTH        = AF_WORDLENGTH,
   parameter int FRACTIONAL_LENGTH = AF_FRACTIONAL_LENGTH
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  ctrl,
   input  logic [WORDLENGTH-1:0] s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   output logic [WORDLENGTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready
);

   if (FRACTIONAL_LENGTH < 0 || FRACTIONAL_LENGTH >= WORDLENGTH) begin : g_bad_format
      $error("FRACTIONAL_LENGTH must lie in [0, WORDLENGTH-1]");
   end

   localparam logic [0:0] PRIME = 1'b0;
   localparam logic [0:0] RUN   = 1'b1;

   logic [0:0]                   state;
   logic                         ctrl_q;
   logic signed [WORDLENGTH-1:0] acc;
   logic signed [WORDLENGTH-1:0] x_prev;

   logic                         in_fire;
   logic                         ctrl_change;
   logic                         prime_eff;
   logic signed [WORDLENGTH-1:0] x_in;
   logic signed [WORDLENGTH-1:0] acc_eff;
   logic signed [WORDLENGTH-1:0] x_prev_eff;
   logic signed [WORDLENGTH-1:0] sum;
   logic signed [WORDLENGTH-1:0] y;
   filter_mode_t                 mode;

   assign s_tready    = !srst && (!m_tvalid || m_tready);
   assign in_fire     = s_tvalid && s_tready;
   assign ctrl_change = (ctrl != ctrl_q);
   assign mode        = filter_mode_t'(ctrl);
   assign x_in        = s_tdata;

   // A ctrl change acts as an immediate return to PRIME, so a sample arriving
   // on that same cycle already sees empty history under the new mode.
   always_comb begin
      prime_eff  = (state == PRIME) || ctrl_change;
      acc_eff    = prime_eff ? '0 : acc;
      x_prev_eff = prime_eff ? '0 : x_prev;
      sum        = acc_eff + x_in;
      y          = (mode == INTEG) ? (x_in - x_prev_eff) : sum;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         state    <= PRIME;
         ctrl_q   <= ctrl;
         acc      <= '0;
         x_prev   <= '0;
         m_tdata  <= '0;
         m_tvalid <= 1'b0;
      end else begin
         ctrl_q <= ctrl;

         // History always tracks both forms; whichever the mode ignores is
         // harmless because a mode change clears it.
         if (in_fire) begin
            state  <= RUN;
            acc    <= sum;
            x_prev <= x_in;
         end else if (ctrl_change) begin
            state  <= PRIME;
            acc    <= '0;
            x_prev <= '0;
         end

         if (in_fire) begin
            m_tdata  <= y;
            m_tvalid <= 1'b1;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/adaptive_filter_inverse.md
ADAPTIVE_FILTER_INVERSE -- requirements
Module: adaptive_filter_inverse

Interface
REQ-001 SHALL have parameter WORDLENGTH, default 14, total sample width in bits.
REQ-002 SHALL have parameter FRACTIONAL_LENGTH, default 6, fractional bits of signed fixed-point sample (Q8.6 at defaults).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port srst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port ctrl  input  1  forward-filter mode being undone: 0 = forward differentiated (block integrates), 1 = forward integrated (block differentiates).
REQ-006 SHALL have port s_tdata  input  WORDLENGTH  signed two's-complement input sample, index range [WORDLENGTH-FRACTIONAL_LENGTH-1:-FRACTIONAL_LENGTH].
REQ-007 SHALL have port s_tvalid  input  1  input sample valid.
REQ-008 SHALL have port s_tready  output  1  block accepts input this cycle.
REQ-009 SHALL have port m_tdata  output  WORDLENGTH  reconstructed sample, same format as s_tdata.
REQ-010 SHALL have port m_tvalid  output  1  output sample valid.
REQ-011 SHALL have port m_tready  input  1  downstream accepts output.

Function
REQ-012 SHALL complete an input transfer on a cycle with s_tvalid && s_tready, and an output transfer on a cycle with m_tvalid && m_tready.
REQ-013 SHALL drive s_tready = !m_tvalid || m_tready (single output register, no combinational path from s_tvalid to m_tvalid).
REQ-014 SHALL present the result of an accepted sample on m_tdata/m_tvalid exactly 1 cycle after the input transfer.
REQ-015 SHALL hold m_tdata and m_tvalid unchanged while m_tvalid && !m_tready.
REQ-016 SHALL deassert m_tvalid after an output transfer with no simultaneous input transfer.
REQ-017 SHALL, on simultaneous input and output transfer, load the new result with m_tvalid staying 1 (full throughput, one sample per cycle).
REQ-018 SHALL in ctrl=0 compute y[n] = acc[n] = acc[n-1] + x[n] (integrator), WORDLENGTH bits, two's-complement wrap, no saturation.
REQ-019 SHALL in ctrl=1 compute y[n] = x[n] - x[n-1] (first difference), WORDLENGTH bits, two's-complement wrap, no saturation.
REQ-020 SHALL use wrap arithmetic so that the cascade of the forward filter and this block reproduces the forward input bit-exactly.
REQ-021 SHALL implement a two-state FSM: PRIME (no history; acc and x_prev treated as 0) and RUN.
REQ-022 SHALL transition PRIME->RUN on the first input transfer, with output y = x for that sample in both modes.
REQ-023 SHALL update acc and x_prev only on input transfers; stalled cycles leave state unchanged.
REQ-024 SHALL register ctrl internally and, on any cycle where ctrl differs from the registered value, clear acc and x_prev to 0 and return to PRIME.
REQ-025 SHALL let an already-registered output be unaffected by a ctrl change.
REQ-026 SHALL, when a ctrl change and an input transfer coincide, process that sample in PRIME under the new ctrl (y = x).

Reset
REQ-027 SHALL on srst=1 set m_tvalid=0, m_tdata=0, acc=0, x_prev=0, FSM=PRIME, registered ctrl=ctrl.
REQ-028 SHALL drive s_tready=0 during srst.
REQ-029 SHALL discard any in-flight output and history on reset mid-stream, with no output for pre-reset samples after srst falls.

Structure
REQ-030 SHALL take WORDLENGTH, FRACTIONAL_LENGTH defaults, a sample_t typedef, and a filter_mode_t enum (DIFF=0, INTEG=1) from shared package adaptive_filter_pkg, shared with the forward filter.
REQ-031 SHALL be a single module with no sub-module; FSM state type local to the module.

Verification (raw integer codes below)
REQ-032 SHALL cover: ctrl=1, inputs 10,30,60,60 back-to-back, m_tready=1 -> outputs 10,20,30,0, each 1 cycle after input.
REQ-033 SHALL cover: ctrl=0, inputs 10,20,30,-60 -> outputs 10,30,60,0.
REQ-034 SHALL cover: ctrl=0, inputs 8191,1 -> outputs 8191,-8192 (wrap, no saturation).
REQ-035 SHALL cover: ctrl=0, stream 5,5,5 with m_tready=0 for 3 cycles after the first output -> m_tdata holds 5, s_tready=0, and outputs after release are 5,10,15 with no loss or duplication.
REQ-036 SHALL cover: ctrl=0, inputs 4,4, then ctrl->1, then inputs 7,9 -> outputs 4,8,7,2.
REQ-037 SHALL cover: 128 random samples through the forward filter then this block, same ctrl, with srst pulsed at sample 64 on both -> output equals input for every sample, counted separately before and after the reset.
